// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//
// N independent switch/button debouncers. Each channel synchronises its raw
// input through a SYNC_STAGES-deep flop chain, then only accepts a new level
// once the synchronised input has disagreed with the filtered level for
// FINAL_VALUE+1 consecutive clocks. Registered one-cycle rise/fall pulses and
// an OR-reduced any_change accompany every accepted transition.
//
// Optional feature (compile-time macro DEBOUNCE_BANK_LONGPRESS_EN):
//   per-channel saturating hold counter that emits a one-cycle long_press
//   pulse HOLD_CYCLES edges after the rise pulse, once per press. Without the
//   macro long_press is tied to 0 and no hold counters are built; the port
//   list is identical in both builds.
//
// Parameters:
//   N            number of channels (1..32)
//   FINAL_VALUE  stability timer terminal count (>= 1)
//   SYNC_STAGES  synchroniser depth (2..4)
//   HOLD_CYCLES  long-press threshold in clk cycles (>= 1)
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   noisy[N]     raw asynchronous input levels
//   debounced[N] filtered levels
//   rise[N]      one-cycle pulse when debounced[i] goes 0->1
//   fall[N]      one-cycle pulse when debounced[i] goes 1->0
//   any_change   OR of all rise and fall bits, same cycle
//   long_press[N] one-cycle pulse on a held press (0 without the macro)
//
// Handshake: none. All outputs are plain registered levels/pulses.
// -----------------------------------------------------------------------------
module debounce_bank #(
   parameter int N           = 4,
   parameter int FINAL_VALUE = 1_999_999,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] noisy,
   output logic [N-1:0] debounced,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic         any_change,
   output logic [N-1:0] long_press
);

   // Elaboration-time guards on the legal parameter ranges.
   if (N < 1 || N > 32) begin : g_bad_n
      $error("debounce_bank: N must be 1..32");
   end
   if (FINAL_VALUE < 1) begin : g_bad_final
      $error("debounce_bank: FINAL_VALUE must be >= 1");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("debounce_bank: SYNC_STAGES must be 2..4");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("debounce_bank: HOLD_CYCLES must be >= 1");
   end

   localparam int            CW        = $clog2(FINAL_VALUE + 1);
   localparam logic [CW-1:0] FINAL_CNT = CW'(FINAL_VALUE);

   logic [N-1:0]  r_sync [SYNC_STAGES];
   logic [CW-1:0] r_cnt  [N];
   logic [N-1:0]  r_debounced;
   logic [N-1:0]  r_rise;
   logic [N-1:0]  r_fall;
   logic          r_any_change;

   logic [N-1:0]  w_sync;
   logic [N-1:0]  w_differ;
   logic [N-1:0]  w_expire;
   logic [N-1:0]  w_rise;
   logic [N-1:0]  w_fall;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_differ = w_sync ^ r_debounced;

   // A channel accepts its new level on the edge where it still disagrees and
   // the timer already sits at terminal count; the counter never goes past it.
   always_comb begin
      w_expire = '0;
      for (int i = 0; i < N; i++) begin
         w_expire[i] = w_differ[i] && (r_cnt[i] == FINAL_CNT);
      end
   end

   assign w_rise = w_expire & w_sync;
   assign w_fall = w_expire & ~w_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= '0;
         end
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= '0;
         end
         r_debounced  <= '0;
         r_rise       <= '0;
         r_fall       <= '0;
         r_any_change <= 1'b0;
      end else begin
         r_sync[0] <= noisy;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
         // Agreement (or acceptance) restarts the interval from zero, so any
         // bounce back to the old level costs the full interval again.
         for (int i = 0; i < N; i++) begin
            if (!w_differ[i] || w_expire[i]) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
         r_debounced  <= r_debounced ^ w_expire;
         r_rise       <= w_rise;
         r_fall       <= w_fall;
         r_any_change <= |w_expire;
      end
   end

   assign debounced  = r_debounced;
   assign rise       = r_rise;
   assign fall       = r_fall;
   assign any_change = r_any_change;

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
   localparam int            HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_FIRE = HW'(HOLD_CYCLES - 1);

   logic [HW-1:0] r_hold [N];
   logic [N-1:0]  r_long_press;

   // The hold counter is 0 in the rise cycle and counts 1,2,.. on the
   // following edges; the pulse is issued on the edge that takes it to
   // HOLD_CYCLES. Saturation at HOLD_CYCLES keeps it to one pulse per press.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            r_hold[i] <= '0;
         end
         r_long_press <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!r_debounced[i]) begin
               r_hold[i] <= '0;
            end else if (r_hold[i] != HOLD_MAX) begin
               r_hold[i] <= r_hold[i] + HW'(1);
            end
            r_long_press[i] <= r_debounced[i] && (r_hold[i] == HOLD_FIRE);
         end
      end
   end

   assign long_press = r_long_press;
`else
   assign long_press = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
//
// Bench for debounce_bank with N=2, FINAL_VALUE=9, SYNC_STAGES=2,
// HOLD_CYCLES=50. Directed sequences (clean step, bounce, simultaneous
// channels, mid-count reset, long press held/released) followed by random
// per-channel toggling with occasional resets. Expected outputs come from a
// history-based reference: a channel takes level v at edge e when every raw
// sample taken at edges e-S-F .. e-S equals v and v differs from the current
// level; samples at or before the last reset edge count as 0.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

   localparam int N = 2;
   localparam int F = 9;
   localparam int S = 2;
   localparam int H = 50;

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   // Expected word layout: {debounced, rise, fall, long_press, any_change}
   localparam int EW = 4 * N + 1;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] noisy;
   logic [N-1:0] debounced;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic         any_change;
   logic [N-1:0] long_press;

   always #5 clk = ~clk;

   debounce_bank #(
      .N           (N),
      .FINAL_VALUE (F),
      .SYNC_STAGES (S),
      .HOLD_CYCLES (H)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .noisy      (noisy),
      .debounced  (debounced),
      .rise       (rise),
      .fall       (fall),
      .any_change (any_change),
      .long_press (long_press)
   );

   // ---------------- scoreboard state ----------------
   int            n_checks   = 0;
   int            n_pass     = 0;
   logic [EW-1:0] exp_q[$];
   logic [N-1:0]  hist_q[$];
   int            edge_no    = 0;
   int            reset_edge = -1;
   logic [N-1:0]  m_deb      = '0;
   int            last_rise [N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_no - 1, got, exp);
      end
   endtask

   // Reference model: one call per rising edge, using the inputs applied to it.
   task automatic model_edge();
      logic [N-1:0] m_rise;
      logic [N-1:0] m_fall;
      logic [N-1:0] m_lp;
      m_rise = '0;
      m_fall = '0;
      m_lp   = '0;
      hist_q.push_back(noisy);
      if (reset) begin
         reset_edge = edge_no;
         m_deb      = '0;
         for (int i = 0; i < N; i++) last_rise[i] = -1;
      end else begin
         for (int i = 0; i < N; i++) begin
            logic want;
            logic smp;
            bit   stable;
            want   = ~m_deb[i];
            stable = 1'b1;
            for (int k = edge_no - S - F; k <= edge_no - S; k++) begin
               smp = (k <= reset_edge) ? 1'b0 : hist_q[k][i];
               if (smp !== want) stable = 1'b0;
            end
            // Long press: level stayed high on every edge since the rise edge.
            if (LP_EN && last_rise[i] >= 0 && (edge_no - last_rise[i]) == H) m_lp[i] = 1'b1;
            if (stable) begin
               m_deb[i] = want;
               if (want) m_rise[i] = 1'b1;
               else      m_fall[i] = 1'b1;
            end
            if (m_rise[i])     last_rise[i] = edge_no;
            else if (!m_deb[i]) last_rise[i] = -1;
         end
      end
      exp_q.push_back({m_deb, m_rise, m_fall, m_lp, |(m_rise | m_fall)});
      edge_no++;
   endtask

   task automatic compare();
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("debounced",  32'(debounced),  32'(e[EW-1 -: N]));
      check("rise",       32'(rise),       32'(e[EW-1-N -: N]));
      check("fall",       32'(fall),       32'(e[EW-1-2*N -: N]));
      check("long_press", 32'(long_press), 32'(e[N:1]));
      check("any_change", 32'(any_change), 32'(e[0]));
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [N-1:0] n, input logic r);
      @(negedge clk);
      noisy = n;
      reset = r;
      @(posedge clk);
      model_edge();
      #1 compare();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [N-1:0] cur;
      int           left [N];
      noisy = '0;
      reset = 1'b1;
      for (int i = 0; i < N; i++) last_rise[i] = -1;

      // reset state
      repeat (3) step(2'b00, 1'b1);

      // clean step on channel 0, channel 1 idle
      repeat (20) step(2'b01, 1'b0);
      repeat (20) step(2'b00, 1'b0);

      // short high burst, never accepted
      repeat (5)  step(2'b01, 1'b0);
      repeat (15) step(2'b00, 1'b0);

      // toggles, then steady high
      step(2'b01, 1'b0);
      step(2'b00, 1'b0);
      step(2'b01, 1'b0);
      step(2'b00, 1'b0);
      step(2'b01, 1'b0);
      step(2'b00, 1'b0);
      repeat (15) step(2'b01, 1'b0);
      repeat (15) step(2'b00, 1'b0);

      // both channels together
      repeat (15) step(2'b11, 1'b0);
      repeat (15) step(2'b00, 1'b0);

      // reset in the middle of a count with channel 0 held high
      repeat (6)  step(2'b01, 1'b0);
      step(2'b01, 1'b1);
      repeat (15) step(2'b01, 1'b0);

      // keep holding past the long-press threshold, then release
      repeat (70) step(2'b01, 1'b0);
      repeat (15) step(2'b00, 1'b0);

      // press released before the threshold
      repeat (30) step(2'b01, 1'b0);
      repeat (20) step(2'b00, 1'b0);

      // random: per-channel toggles with mixed short/long hold times
      cur = '0;
      for (int i = 0; i < N; i++) left[i] = 1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            left[i]--;
            if (left[i] == 0) begin
               cur[i]  = ~cur[i];
               left[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(40, 90))
                                                     : int'($urandom_range(1, 14));
            end
         end
         step(cur, $urandom_range(0, 499) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL have parameter N, default 4: number of independent debounce channels, legal range 1..32.
REQ-002 The block SHALL have parameter FINAL_VALUE, default 1_999_999: terminal count of the stability timer (20 ms at 100 MHz), minimum 1.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-004 The block SHALL have parameter HOLD_CYCLES, default 100_000_000: long-press threshold in clk cycles, minimum 1.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port noisy, input, N bits: raw asynchronous button/switch levels.
REQ-008 The block SHALL have port debounced, output, N bits: filtered levels.
REQ-009 The block SHALL have port rise, output, N bits: one-cycle pulse when debounced[i] goes 0->1.
REQ-010 The block SHALL have port fall, output, N bits: one-cycle pulse when debounced[i] goes 1->0.
REQ-011 The block SHALL have port any_change, output, 1 bit: OR of all rise and fall bits.
REQ-012 The block SHALL have port long_press, output, N bits: one-cycle pulse per channel on a held press.

Function
REQ-013 Each channel SHALL pass noisy[i] through a SYNC_STAGES-deep flop chain; the last stage is sync[i].
REQ-014 Each channel SHALL have a private counter of width $clog2(FINAL_VALUE+1); channels SHALL share no state.
REQ-015 On any edge where sync[i]==debounced[i], counter[i] SHALL load 0.
REQ-016 On an edge where sync[i]!=debounced[i] and counter[i]<FINAL_VALUE, counter[i] SHALL increment by 1.
REQ-017 On an edge where sync[i]!=debounced[i] and counter[i]==FINAL_VALUE, debounced[i] SHALL load sync[i] and counter[i] SHALL load 0.
REQ-018 Latency: call edge 0 the first edge that samples a new stable noisy level. debounced SHALL change at edge SYNC_STAGES+FINAL_VALUE.
REQ-019 Any bounce back to the old level before that edge SHALL restart the full interval, counted from the last transition.
REQ-020 rise[i]/fall[i] SHALL be registered and SHALL assert in exactly the cycle debounced[i] first shows its new value, for one cycle only.
REQ-021 any_change SHALL be registered and asserted in the same cycle as the pulses it reflects.
REQ-022 Simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-023 The counter SHALL never wrap: values above FINAL_VALUE SHALL be unreachable.

Reset
REQ-024 While reset=1 at a clk edge, all synchroniser flops, counters and hold counters SHALL load 0, and debounced, rise, fall, any_change and long_press SHALL load 0.
REQ-025 Reset mid-count SHALL discard progress; a still-asserted input SHALL need the full REQ-018 latency counted from the first post-reset edge, and SHALL then produce a rise pulse.

Configuration
REQ-026 The block SHALL compile long-press detection in only when macro DEBOUNCE_BANK_LONGPRESS_EN is defined.
REQ-027 With DEBOUNCE_BANK_LONGPRESS_EN defined, each channel SHALL run a saturating hold counter that clears while debounced[i]=0 and increments each cycle while debounced[i]=1.
REQ-028 With DEBOUNCE_BANK_LONGPRESS_EN defined, long_press[i] SHALL pulse for one cycle at the HOLD_CYCLES-th edge after the rise[i] cycle, at most once per press.
REQ-029 With DEBOUNCE_BANK_LONGPRESS_EN defined, a release before that edge SHALL produce no long_press pulse.
REQ-030 Without DEBOUNCE_BANK_LONGPRESS_EN, long_press SHALL be constant 0, no hold counters SHALL exist, and the port list SHALL be unchanged.

Verification (N=2, FINAL_VALUE=9, SYNC_STAGES=2, HOLD_CYCLES=50)
REQ-031 Clean step: noisy[0] 0->1, first sampled at edge 0 -> debounced[0]=1 and rise[0]=1 at edge 11, any_change=1 at edge 11, rise[0]=0 at edge 12, channel 1 unchanged.
REQ-032 Bounce: noisy[0] high for 5 cycles then low -> debounced[0], rise and fall stay 0 throughout; then 3 toggles followed by a steady high -> debounced[0] rises 11 edges after the last toggle.
REQ-033 Simultaneous: noisy=2'b11 at edge 0 -> debounced=2'b11 and rise=2'b11 at edge 11; noisy=2'b00 later -> fall=2'b11 in the same cycle.
REQ-034 Reset mid-operation: reset=1 for 1 cycle at edge 6 with noisy[0] held high -> debounced[0] stays 0 and all counters read 0; debounced[0] rises 11 edges after the first post-reset edge.
REQ-035 Long press with the macro defined: noisy[0] held high -> long_press[0] pulses exactly once, 50 edges after rise[0].
REQ-036 Long press, release case: noisy[0] released after 30 cycles high -> no long_press pulse; with the macro undefined, long_press=0 in every case.
